// File: rtl/survivor_mem_pkg.sv
// Shared constants and FSM state type for the Viterbi survivor-path memory.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package survivor_mem_pkg;

    localparam int MAX_STATE_REG_NUM = 4;    // state register width
    localparam int MAX_STATE_NUM     = 16;   // trellis states = 2**MAX_STATE_REG_NUM
    localparam int SURV_DEPTH        = 96;   // max trellis steps per frame
    localparam int PM_WIDTH          = 8;    // unsigned path-metric width

    // ACQ: capture steps; SEL: present start node; READ: replay newest-first;
    // HOLD: park on step 0 until the decoded frame is acknowledged.
    typedef enum logic [1:0] {
        ACQ  = 2'd0,
        SEL  = 2'd1,
        READ = 2'd2,
        HOLD = 2'd3
    } sm_state_t;

endpackage

// File: rtl/survivor_mem_pm_argmin.sv
// Purpose: index of the smallest of NUM_ST unsigned path metrics, lowest index wins ties.
// Latency: combinational, zero cycles.
// Backpressure: none (pure function of its input).
// Ports: pm - NUM_ST packed metrics of PM_W bits; min_idx - ST_W-bit index of the minimum.
module pm_argmin
    import survivor_mem_pkg::*;
#(
    parameter int NUM_ST = MAX_STATE_NUM,
    parameter int ST_W   = MAX_STATE_REG_NUM,
    parameter int PM_W   = PM_WIDTH
) (
    input  logic [NUM_ST-1:0][PM_W-1:0] pm,
    output logic [ST_W-1:0]             min_idx
);

    logic [PM_W-1:0] best;

    // Strict less-than keeps the earliest index on equal metrics.
    always_comb begin
        best    = pm[0];
        min_idx = '0;
        for (int i = 1; i < NUM_ST; i++) begin
            if (pm[i] < best) begin
                best    = pm[i];
                min_idx = ST_W'(i);
            end
        end
    end

endmodule

// File: rtl/survivor_mem.sv
// Purpose: survivor-path memory between ACS and traceback; stores one back-pointer vector per step,
//          latches the argmin end state at frame end, then replays steps newest-first.
// Latency: last en_s edge T -> SEL cycle T+1 -> first READ cycle T+2 -> o_td_empty at T+1+N.
// Backpressure: o_busy high outside ACQ (en_s then ignored); HOLD parks until i_frame_ack.
// Ports:
//   clk, rst (sync, active-low)
//   en_s, i_last, i_prv_st, i_pm   - ACS step input (i_last/i_pm only matter with en_s)
//   i_frame_ack                    - downstream has consumed the decoded frame
//   o_busy, o_sel_node             - ACS hold-off, traceback start node
//   o_bck_prv_st, o_en_t, o_td_empty - replayed back-pointers, traceback enable, step-0 flag
module survivor_mem
    import survivor_mem_pkg::*;
#(
    parameter int ST_W   = MAX_STATE_REG_NUM,
    parameter int NUM_ST = MAX_STATE_NUM,
    parameter int DEPTH  = SURV_DEPTH,
    parameter int PM_W   = PM_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en_s,
    input  logic                          i_last,
    input  logic [NUM_ST-1:0][ST_W-1:0]   i_prv_st,
    input  logic [NUM_ST-1:0][PM_W-1:0]   i_pm,
    input  logic                          i_frame_ack,
    output logic                          o_busy,
    output logic [ST_W-1:0]               o_sel_node,
    output logic [NUM_ST-1:0][ST_W-1:0]   o_bck_prv_st,
    output logic                          o_en_t,
    output logic                          o_td_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    sm_state_t                  state;
    sm_state_t                  state_nxt;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [ST_W-1:0]            sel_node;
    logic [ST_W-1:0]            min_idx;
    logic                       acq_wr;
    logic                       acq_end;
    logic [NUM_ST-1:0][ST_W-1:0] mem [DEPTH];

    pm_argmin #(
        .NUM_ST (NUM_ST),
        .ST_W   (ST_W),
        .PM_W   (PM_W)
    ) u_argmin (
        .pm      (i_pm),
        .min_idx (min_idx)
    );

    // Steps are only accepted while acquiring; the frame closes on i_last or
    // when the final slot is written, so the write pointer never passes DEPTH-1.
    assign acq_wr  = (state == ACQ) && en_s;
    assign acq_end = acq_wr && (i_last || (wr_ptr == PTR_W'(DEPTH - 1)));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ACQ;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ACQ:     if (acq_end) state_nxt = SEL;
            SEL:     state_nxt = READ;
            READ:    if (rd_ptr == '0) state_nxt = HOLD;
            HOLD:    if (i_frame_ack) state_nxt = ACQ;
            default: state_nxt = ACQ;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_busy       = 1'b0;
        o_en_t       = 1'b0;
        o_td_empty   = 1'b0;
        o_bck_prv_st = '0;
        case (state)
            ACQ: begin
                o_busy = 1'b0;
            end
            SEL: begin
                o_busy = 1'b1;
            end
            READ: begin
                o_busy       = 1'b1;
                o_en_t       = 1'b1;
                o_td_empty   = (rd_ptr == '0);
                o_bck_prv_st = mem[rd_ptr];
            end
            HOLD: begin
                // Keep traceback enabled on step 0 so its done flag and data stay put.
                o_busy       = 1'b1;
                o_en_t       = 1'b1;
                o_td_empty   = 1'b1;
                o_bck_prv_st = mem[0];
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

    assign o_sel_node = sel_node;

    // ---------------- Pointers and start node ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sel_node <= '0;
        end else begin
            if (acq_wr) begin
                if (acq_end) begin
                    // Replay begins at the step written on this very edge.
                    rd_ptr   <= wr_ptr;
                    sel_node <= min_idx;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
            if ((state == READ) && (rd_ptr != '0)) begin
                rd_ptr <= rd_ptr - 1'b1;
            end
            if ((state == HOLD) && i_frame_ack) begin
                wr_ptr <= '0;
            end
        end
    end

    // ---------------- Back-pointer storage (no reset needed) ----------------
    always_ff @(posedge clk) begin
        if (rst && acq_wr) begin
            mem[wr_ptr] <= i_prv_st;
        end
    end

endmodule

// File: tb/tb_survivor_mem.sv
// Purpose: directed self-checking bench for survivor_mem (full, short, tie, busy guard, ack, reset).
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_survivor_mem;

    localparam int ST_W   = 4;
    localparam int NUM_ST = 16;
    localparam int DEPTH  = 96;
    localparam int PM_W   = 8;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        en_s;
    logic                        i_last;
    logic [NUM_ST-1:0][ST_W-1:0] i_prv_st;
    logic [NUM_ST-1:0][PM_W-1:0] i_pm;
    logic                        i_frame_ack;
    logic                        o_busy;
    logic [ST_W-1:0]             o_sel_node;
    logic [NUM_ST-1:0][ST_W-1:0] o_bck_prv_st;
    logic                        o_en_t;
    logic                        o_td_empty;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    survivor_mem #(
        .ST_W   (ST_W),
        .NUM_ST (NUM_ST),
        .DEPTH  (DEPTH),
        .PM_W   (PM_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en_s         (en_s),
        .i_last       (i_last),
        .i_prv_st     (i_prv_st),
        .i_pm         (i_pm),
        .i_frame_ack  (i_frame_ack),
        .o_busy       (o_busy),
        .o_sel_node   (o_sel_node),
        .o_bck_prv_st (o_bck_prv_st),
        .o_en_t       (o_en_t),
        .o_td_empty   (o_td_empty)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Back-pointer vector for step k: pattern 0 is (s+k)%16, pattern 1 is (3s+k+7)%16.
    function automatic logic [63:0] pat_vec(input int p, input int k);
        logic [63:0] v;
        v = '0;
        for (int s = 0; s < NUM_ST; s++) begin
            if (p == 0) v[s*4 +: 4] = 4'((s + k) % 16);
            else        v[s*4 +: 4] = 4'((3 * s + k + 7) % 16);
        end
        return v;
    endfunction

    // Metrics with a unique minimum of 3 at min_state, or all 8'h40 for a tie.
    function automatic logic [127:0] pm_vec(input int min_state, input bit tie);
        logic [127:0] v;
        v = '0;
        for (int s = 0; s < NUM_ST; s++) begin
            if (tie)                 v[s*8 +: 8] = 8'h40;
            else if (s == min_state) v[s*8 +: 8] = 8'd3;
            else                     v[s*8 +: 8] = 8'(20 + s);
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int p, input int n, input bit use_last,
                              input int min_state, input bit tie);
        for (int k = 0; k < n; k++) begin
            if (use_last && (k == 4)) begin
                // A lone i_last must not close the frame.
                en_s   = 1'b0;
                i_last = 1'b1;
                tick();
                check("lone_last_busy", 64'(o_busy), 64'd0);
            end
            en_s     = 1'b1;
            i_prv_st = pat_vec(p, k);
            i_last   = use_last && (k == n - 1);
            i_pm     = (k == n - 1) ? pm_vec(min_state, tie) : pm_vec((min_state + 7) % 16, 1'b0);
            tick();
            if (k == 50) check("acq_busy_mid", 64'(o_busy), 64'd0);
        end
        en_s   = 1'b0;
        i_last = 1'b0;
    endtask

    task automatic check_sel(input int exp_sel);
        check("sel_busy",  64'(o_busy), 64'd1);
        check("sel_en_t",  64'(o_en_t), 64'd0);
        check("sel_empty", 64'(o_td_empty), 64'd0);
        check("sel_node",  64'(o_sel_node), 64'(exp_sel));
    endtask

    task automatic replay(input int p, input int n, input bit poke);
        for (int j = 0; j < n; j++) begin
            if (poke) begin
                en_s     = j[0];
                i_last   = 1'b1;
                i_prv_st = '1;
            end
            tick();
            check("rd_en_t",  64'(o_en_t), 64'd1);
            check("rd_data",  64'(o_bck_prv_st), pat_vec(p, n - 1 - j));
            check("rd_empty", 64'(o_td_empty), 64'(j == n - 1));
        end
        en_s   = 1'b0;
        i_last = 1'b0;
    endtask

    task automatic hold(input int p, input int cycles, input bit poke);
        for (int i = 0; i < cycles; i++) begin
            en_s     = poke;
            i_prv_st = '1;
            tick();
            check("hold_en_empty", {62'd0, o_en_t, o_td_empty}, 64'd3);
            check("hold_data", 64'(o_bck_prv_st), pat_vec(p, 0));
        end
        en_s        = 1'b0;
        i_frame_ack = 1'b1;
        tick();
        i_frame_ack = 1'b0;
        check("ack_busy",  64'(o_busy), 64'd0);
        check("ack_en_t",  64'(o_en_t), 64'd0);
        check("ack_empty", 64'(o_td_empty), 64'd0);
    endtask

    initial begin
        rst         = 1'b0;
        en_s        = 1'b0;
        i_last      = 1'b0;
        i_prv_st    = '0;
        i_pm        = '0;
        i_frame_ack = 1'b0;
        tick();
        tick();
        check("rst_busy",  64'(o_busy), 64'd0);
        check("rst_en_t",  64'(o_en_t), 64'd0);
        check("rst_empty", 64'(o_td_empty), 64'd0);
        check("rst_sel",   64'(o_sel_node), 64'd0);
        check("rst_bck",   64'(o_bck_prv_st), 64'd0);
        rst = 1'b1;
        tick();

        // Full frame, closed by depth (no i_last), min metric at state 5,
        // en_s pokes during SEL/READ/HOLD must leave the stored frame intact.
        send_frame(0, DEPTH, 1'b0, 5, 1'b0);
        check_sel(5);
        check("full_first_bit0", 64'(o_bck_prv_st[0]), 64'd0);
        replay(0, DEPTH, 1'b1);
        check("full_sel_stable", 64'(o_sel_node), 64'd5);
        hold(0, 20, 1'b1);

        // Short frame closed by i_last on the 10th step with tied metrics.
        send_frame(1, 10, 1'b1, 0, 1'b1);
        check_sel(0);
        replay(1, 10, 1'b0);
        hold(1, 1, 1'b0);

        // Reset in the middle of replay, then a fresh 4-step frame.
        send_frame(0, 50, 1'b1, 9, 1'b0);
        check_sel(9);
        for (int j = 0; j < 10; j++) tick();
        check("mid_read_step40", 64'(o_bck_prv_st), pat_vec(0, 40));
        check("mid_read_first", 64'(o_bck_prv_st[0]), 64'd8);
        rst = 1'b0;
        tick();
        check("mrst_busy",  64'(o_busy), 64'd0);
        check("mrst_en_t",  64'(o_en_t), 64'd0);
        check("mrst_empty", 64'(o_td_empty), 64'd0);
        check("mrst_sel",   64'(o_sel_node), 64'd0);
        check("mrst_bck",   64'(o_bck_prv_st), 64'd0);
        rst = 1'b1;
        send_frame(1, 4, 1'b1, 2, 1'b0);
        check_sel(2);
        replay(1, 4, 1'b0);
        hold(1, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
